// File: rtl/axi_rd_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_rr_arbiter
// Description : Round-robin arbiter sharing one AXI4 read port (AR/R) among
//               NUM_M read masters. The grant is registered and held for a
//               whole burst, until the R beat carrying rlast handshakes.
//               The number of beats received is checked against arlen.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rd_rr_arbiter #(
    parameter  int NUM_M  = 2,
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    parameter  int ID_W   = 4,
    localparam int IDX_W  = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
    input  logic                    clk,
    input  logic                    rst,        // asynchronous, active-low
    input  logic [NUM_M-1:0]        m_arvalid,
    output logic [NUM_M-1:0]        m_arready,
    input  logic [NUM_M*ADDR_W-1:0] m_araddr,
    input  logic [NUM_M*ID_W-1:0]   m_arid,
    input  logic [NUM_M*8-1:0]      m_arlen,
    input  logic [NUM_M*3-1:0]      m_arsize,
    input  logic [NUM_M*2-1:0]      m_arburst,
    output logic [NUM_M-1:0]        m_rvalid,
    input  logic [NUM_M-1:0]        m_rready,
    output logic [DATA_W-1:0]       m_rdata,
    output logic [1:0]              m_rresp,
    output logic                    m_rlast,
    output logic [ID_W-1:0]         m_rid,
    output logic                    s_arvalid,
    input  logic                    s_arready,
    output logic [ADDR_W-1:0]       s_araddr,
    output logic [ID_W-1:0]         s_arid,
    output logic [7:0]              s_arlen,
    output logic [2:0]              s_arsize,
    output logic [1:0]              s_arburst,
    input  logic                    s_rvalid,
    output logic                    s_rready,
    input  logic [DATA_W-1:0]       s_rdata,
    input  logic [1:0]              s_rresp,
    input  logic                    s_rlast,
    input  logic [ID_W-1:0]         s_rid,
    output logic [IDX_W-1:0]        grant_idx,
    output logic                    busy,
    output logic                    len_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t           state_q,    state_d;
    logic [IDX_W-1:0] grant_q,    grant_d;
    logic [IDX_W-1:0] rr_ptr_q,   rr_ptr_d;
    logic [7:0]       beat_cnt_q, beat_cnt_d;

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic             ar_hs;
    logic             r_hs;

    // Round-robin scan: first requester starting at rr_ptr and wrapping
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_ptr_q;
        for (int k = 0; k < NUM_M; k++) begin
            if (!win_found && m_arvalid[(int'(rr_ptr_q) + k) % NUM_M]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'((int'(rr_ptr_q) + k) % NUM_M);
            end
        end
    end

    assign ar_hs = (state_q == ST_ADDR) && m_arvalid[grant_q] && s_arready;
    assign r_hs  = (state_q == ST_DATA) && s_rvalid && m_rready[grant_q];

    // AR payload follows the current owner; R payload is broadcast
    assign s_araddr  = m_araddr [int'(grant_q)*ADDR_W +: ADDR_W];
    assign s_arid    = m_arid   [int'(grant_q)*ID_W   +: ID_W];
    assign s_arlen   = m_arlen  [int'(grant_q)*8      +: 8];
    assign s_arsize  = m_arsize [int'(grant_q)*3      +: 3];
    assign s_arburst = m_arburst[int'(grant_q)*2      +: 2];
    assign m_rdata   = s_rdata;
    assign m_rresp   = s_rresp;
    assign m_rlast   = s_rlast;
    assign m_rid     = s_rid;
    assign grant_idx = grant_q;
    assign busy      = (state_q != ST_IDLE);

    // Handshake steering: only the granted master is connected to the port
    always_comb begin
        m_arready = '0;
        m_rvalid  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        len_err   = 1'b0;
        case (state_q)
            ST_ADDR: begin
                s_arvalid          = m_arvalid[grant_q];
                m_arready[grant_q] = s_arready;
            end
            ST_DATA: begin
                m_rvalid[grant_q] = s_rvalid;
                s_rready          = m_rready[grant_q];
                // Early rlast or a missing rlast on the expected final beat
                len_err = r_hs && ((s_rlast && (beat_cnt_q != 8'd0)) ||
                                   (!s_rlast && (beat_cnt_q == 8'd0)));
            end
            default: ;
        endcase
    end

    // Next-state logic for arbitration FSM, pointer and beat counter
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    grant_d = win_idx;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                // A dropped arvalid keeps the grant; nothing is reassigned
                if (ar_hs) begin
                    beat_cnt_d = s_arlen;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_hs) begin
                    if (beat_cnt_q != 8'd0) begin
                        beat_cnt_d = beat_cnt_q - 8'd1;
                    end
                    // The FSM always follows rlast, even on a length mismatch
                    if (s_rlast) begin
                        rr_ptr_d = IDX_W'((int'(grant_q) + 1) % NUM_M);
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule
`default_nettype wire
